// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch slice.
//   fetch_state_e - fetch sequencer states (IDLE, VALID, HALTED)
//   DEF_*         - default widths and reset PC used by fetch_unit and instr_mem
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VALID  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam int unsigned DEF_INSTR_W  = 16;
  localparam int unsigned DEF_ADDR_W   = 4;
  localparam int unsigned DEF_COUNT_W  = 16;
  localparam int unsigned DEF_RESET_PC = 0;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: synchronous single-write / single-read RAM, read-before-write.
// Ports:
//   clk, reset      - clock; reset clears only the read register, never the array
//   we/waddr/wdata  - write port, takes effect at the clock edge
//   re/raddr        - read request; rdata_q updates at the next edge when re=1
//   rdata_q         - registered read data, held while re=0
module instr_mem
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic               re,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata_q
);

  logic [INSTR_W-1:0] mem [2**ADDR_W];

  // Array write is independent of reset so program contents survive it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Nonblocking update: a same-address read in the write cycle sees old data.
  always_ff @(posedge clk) begin
    if (reset)   rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer. Holds the PC and instruction memory
// and streams {out_pc, out_instr} to decode over a valid/ready handshake.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   imem_we/imem_waddr/imem_wdata    - program-load write port
//   run, halt_req                    - start/resume, stop after next handshake
//   redirect_valid, redirect_pc      - branch redirect of the fetch stream
//   out_valid/out_ready/out_instr/out_pc - decode-side handshake
//   pc, halted, pc_wrapped, fetch_count  - status
// Optional feature: define FETCH_WRAP_HALT_EN to halt after the instruction at
// the last address is handshaken instead of continuing from address 0.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned INSTR_W  = DEF_INSTR_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned RESET_PC = DEF_RESET_PC,
  parameter int unsigned COUNT_W  = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_we,
  input  logic [ADDR_W-1:0]  imem_waddr,
  input  logic [INSTR_W-1:0] imem_wdata,
  input  logic               run,
  input  logic               halt_req,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted,
  output logic               pc_wrapped,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [ADDR_W-1:0] PC_MAX = '1;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (v == '1) ? v : v + COUNT_W'(1);
  endfunction

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
  logic               wrapped_q, wrapped_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               load;
  logic [ADDR_W-1:0]  load_addr;
  logic               hs;

  assign hs = (state_q == ST_VALID) && out_ready;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= ADDR_W'(RESET_PC);
      out_pc_q  <= '0;
      wrapped_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_pc_q  <= out_pc_d;
      wrapped_q <= wrapped_d;
      count_q   <= count_d;
    end
  end

  // Next-state and next-PC logic. A "load" fetches load_addr into the output
  // register and advances the PC past it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_pc_d  = out_pc_q;
    wrapped_d = wrapped_q;
    count_d   = count_q;
    load      = 1'b0;
    load_addr = pc_q;

    case (state_q)
      ST_IDLE: begin
        if (run) begin
          load      = 1'b1;
          load_addr = redirect_valid ? redirect_pc : pc_q;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
        end
      end
      ST_VALID: begin
        if (halt_req && hs) begin
          // Halt owns the state; a simultaneous redirect only retargets the PC.
          state_d = ST_HALTED;
          if (redirect_valid) pc_d = redirect_pc;
        end else if (redirect_valid) begin
          load      = 1'b1;
          load_addr = redirect_pc;
        end else if (hs) begin
`ifdef FETCH_WRAP_HALT_EN
          if (out_pc_q == PC_MAX) begin
            state_d = ST_HALTED;
          end else begin
            load      = 1'b1;
            load_addr = pc_q;
          end
`else
          load      = 1'b1;
          load_addr = pc_q;
`endif
        end
      end
      ST_HALTED: begin
        if (run) begin
          load      = 1'b1;
          load_addr = pc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      state_d  = ST_VALID;
      out_pc_d = load_addr;
      pc_d     = load_addr + ADDR_W'(1);
      if (load_addr == PC_MAX) wrapped_d = 1'b1;
    end

    if (hs) count_d = sat_inc(count_q);
  end

  // Outputs decoded from state.
  always_comb begin
    out_valid = (state_q == ST_VALID);
    halted    = (state_q == ST_HALTED);
  end

  assign pc          = pc_q;
  assign out_pc      = out_pc_q;
  assign pc_wrapped  = wrapped_q;
  assign fetch_count = count_q;

  instr_mem #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_imem (
    .clk     (clk),
    .reset   (reset),
    .we      (imem_we),
    .waddr   (imem_waddr),
    .wdata   (imem_wdata),
    .re      (load),
    .raddr   (load_addr),
    .rdata_q (out_instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 4;
  localparam int COUNT_W = 4;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               reset;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_waddr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               run;
  logic               halt_req;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic [ADDR_W-1:0]  pc;
  logic               halted;
  logic               pc_wrapped;
  logic [COUNT_W-1:0] fetch_count;

  always #5 clk = ~clk;

  fetch_unit #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .RESET_PC (0),
    .COUNT_W  (COUNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata),
    .run            (run),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .pc             (pc),
    .halted         (halted),
    .pc_wrapped     (pc_wrapped),
    .fetch_count    (fetch_count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  int checks   = 0;
  int failures = 0;
  logic [INSTR_W-1:0] ref_mem [DEPTH];
  exp_t exp_q[$];
  exp_t mon_e;
  int   start_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input int a);
    exp_t e;
    e.pc    = ADDR_W'(a);
    e.instr = ref_mem[a];
    exp_q.push_back(e);
  endtask

  // Scoreboard: every handshake must match the next expected {pc, instr}.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_hs_pc", 32'(out_pc), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_pc", 32'(out_pc), 32'(mon_e.pc));
        check_eq("sb_instr", 32'(out_instr), 32'(mon_e.instr));
      end
    end
  end

  initial begin
    reset = 1'b1; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0;
    run = 1'b0; halt_req = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      ref_mem[i] = (i < 4) ? 16'(16'h1111 * (i + 1)) : 16'(16'hA000 + i);

    // Program load (held under reset: array must survive it).
    tick(1);
    for (int i = 0; i < DEPTH; i++) begin
      imem_we = 1'b1; imem_waddr = ADDR_W'(i); imem_wdata = ref_mem[i];
      tick(1);
    end
    imem_we = 1'b0;
    tick(1);
    check_eq("rst_out_valid", 32'(out_valid), 0);
    check_eq("rst_out_instr", 32'(out_instr), 0);
    check_eq("rst_out_pc", 32'(out_pc), 0);
    check_eq("rst_pc", 32'(pc), 0);
    check_eq("rst_halted", 32'(halted), 0);
    check_eq("rst_wrapped", 32'(pc_wrapped), 0);
    check_eq("rst_count", 32'(fetch_count), 0);
    reset = 1'b0;

    // Basic stream of four words, halted on the fourth handshake.
    for (int i = 0; i < 4; i++) expect_word(i);
    run = 1'b1; out_ready = 1'b1;
    check_eq("pre_run_valid", 32'(out_valid), 0);
    tick(1);
    check_eq("run_lat_valid", 32'(out_valid), 1);
    check_eq("run_lat_pc", 32'(out_pc), 0);
    check_eq("run_lat_instr", 32'(out_instr), 32'h1111);
    check_eq("run_next_pc", 32'(pc), 1);
    run = 1'b0;
    tick(3);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    check_eq("s1_halted", 32'(halted), 1);
    check_eq("s1_valid", 32'(out_valid), 0);
    check_eq("s1_count", 32'(fetch_count), 4);
    check_eq("s1_pc", 32'(pc), 4);

    // Redirect in IDLE without run only moves the PC; redirect to 0 does not wrap.
    reset = 1'b1; tick(1); reset = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 4'd5;
    tick(1);
    check_eq("idle_redir_pc", 32'(pc), 5);
    check_eq("idle_redir_valid", 32'(out_valid), 0);
    redirect_pc = 4'd0;
    tick(1);
    check_eq("idle_redir0_pc", 32'(pc), 0);
    check_eq("idle_redir0_wrap", 32'(pc_wrapped), 0);
    redirect_valid = 1'b0;

    // Back-pressure: hold at out_pc=2.
    expect_word(0); expect_word(1);
    run = 1'b1; out_ready = 1'b1;
    tick(1);
    run = 1'b0;
    tick(2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_eq("stall_pc", 32'(out_pc), 2);
      check_eq("stall_instr", 32'(out_instr), 32'h3333);
      check_eq("stall_next_pc", 32'(pc), 3);
      check_eq("stall_count", 32'(fetch_count), 2);
    end

    // Redirect discards the pending, un-handshaken word.
    redirect_valid = 1'b1; redirect_pc = 4'd9;
    tick(1);
    redirect_valid = 1'b0;
    check_eq("redir_out_pc", 32'(out_pc), 9);
    check_eq("redir_instr", 32'(out_instr), 32'(ref_mem[9]));
    check_eq("redir_pc", 32'(pc), 10);
    check_eq("redir_count", 32'(fetch_count), 2);

    // Halt request waits for the handshake.
    halt_req = 1'b1;
    tick(2);
    check_eq("halt_wait_valid", 32'(out_valid), 1);
    check_eq("halt_wait_halted", 32'(halted), 0);
    check_eq("halt_wait_pc", 32'(out_pc), 9);
    expect_word(9);
    out_ready = 1'b1;
    tick(1);
    halt_req = 1'b0;
    check_eq("halt_halted", 32'(halted), 1);
    check_eq("halt_valid", 32'(out_valid), 0);
    check_eq("halt_count", 32'(fetch_count), 3);
    check_eq("halt_pc", 32'(pc), 10);

    // Resume, then redirect to 14 in a handshake cycle and stream across the wrap.
    expect_word(10);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    check_eq("resume_out_pc", 32'(out_pc), 10);
    redirect_valid = 1'b1; redirect_pc = 4'd14;
    expect_word(14);
    tick(1);
    redirect_valid = 1'b0;
    check_eq("wrap14_out_pc", 32'(out_pc), 14);
    check_eq("wrap14_count", 32'(fetch_count), 4);
    check_eq("wrap14_pc", 32'(pc), 15);
    check_eq("wrap14_wrapped", 32'(pc_wrapped), 0);
    expect_word(15);
    tick(1);
    check_eq("wrap15_out_pc", 32'(out_pc), 15);
    check_eq("wrap15_pc", 32'(pc), 0);
    check_eq("wrap15_wrapped", 32'(pc_wrapped), 1);
`ifdef FETCH_WRAP_HALT_EN
    tick(1);
    check_eq("wraphalt_halted", 32'(halted), 1);
    check_eq("wraphalt_valid", 32'(out_valid), 0);
    check_eq("wraphalt_pc", 32'(pc), 0);
    check_eq("wraphalt_wrapped", 32'(pc_wrapped), 1);
    check_eq("wraphalt_count", 32'(fetch_count), 6);
    start_pc = 0;
`else
    expect_word(0);
    tick(1);
    check_eq("wrap0_out_pc", 32'(out_pc), 0);
    check_eq("wrap0_instr", 32'(out_instr), 32'h1111);
    check_eq("wrap0_pc", 32'(pc), 1);
    check_eq("wrap0_halted", 32'(halted), 0);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    check_eq("wrap0_halt", 32'(halted), 1);
    check_eq("wrap0_count", 32'(fetch_count), 7);
    start_pc = 1;
`endif

    // Twelve more handshakes drive the 4-bit counter into saturation.
    for (int k = 0; k < 12; k++) expect_word(start_pc + k);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    tick(11);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    check_eq("sat_count", 32'(fetch_count), 15);
    check_eq("sat_halted", 32'(halted), 1);

    // Redirect ignored while HALTED.
    redirect_valid = 1'b1; redirect_pc = 4'd3;
    tick(1);
    redirect_valid = 1'b0;
    check_eq("halted_redir_pc", 32'(pc), 32'(start_pc + 12));
    check_eq("halted_redir_state", 32'(halted), 1);

    // Reset mid-stream beats a simultaneous redirect and run.
    out_ready = 1'b0; run = 1'b1;
    tick(1);
    check_eq("pre_reset_valid", 32'(out_valid), 1);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 4'd7;
    tick(1);
    check_eq("mrst_out_valid", 32'(out_valid), 0);
    check_eq("mrst_out_instr", 32'(out_instr), 0);
    check_eq("mrst_out_pc", 32'(out_pc), 0);
    check_eq("mrst_pc", 32'(pc), 0);
    check_eq("mrst_halted", 32'(halted), 0);
    check_eq("mrst_wrapped", 32'(pc_wrapped), 0);
    check_eq("mrst_count", 32'(fetch_count), 0);
    reset = 1'b0; redirect_valid = 1'b0; run = 1'b0;

    // Memory kept across reset; same-cycle write to the read address returns old data.
    expect_word(0);
    imem_we = 1'b1; imem_waddr = 4'd0; imem_wdata = 16'hBEEF;
    run = 1'b1; out_ready = 1'b1;
    tick(1);
    imem_we = 1'b0; run = 1'b0;
    ref_mem[0] = 16'hBEEF;
    check_eq("rbw_old_instr", 32'(out_instr), 32'h1111);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    reset = 1'b1; tick(1); reset = 1'b0;
    expect_word(0);
    run = 1'b1;
    tick(1);
    run = 1'b0;
    check_eq("rbw_new_instr", 32'(out_instr), 32'hBEEF);
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0; out_ready = 1'b0;
    tick(2);
    check_eq("sb_empty", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
